// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline: default widths, opcodes,
// decode-stage state encodings and instruction field positions.
package cpu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_OPCD_W = 5;
    localparam int INST_W     = 32;

    // Opcode that marks a pipeline bubble
    localparam logic [DEF_OPCD_W-1:0] OPCD_NOP = 5'd0;

    // Decode-stage FSM; encodings 4-7 are unused and fall back to IDLE
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_HOLD   = 3'd2,
        ST_FLUSH  = 3'd3
    } estado_e;

    // Instruction word layout: opcd | opt | rd | rs1 | rs2 | ... ; imm overlaps rs2
    localparam int OPCD_MSB = 31;
    localparam int OPCD_LSB = 27;
    localparam int OPT_POS  = 26;
    localparam int RD_MSB   = 25;
    localparam int RD_LSB   = 21;
    localparam int RS1_MSB  = 20;
    localparam int RS1_LSB  = 16;
    localparam int RS2_MSB  = 15;
    localparam int RS2_LSB  = 11;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

endpackage

// File: rtl/reg_file.sv
// 2-read / 1-write register file. Reads are combinational, the write lands
// on the rising edge, r0 always reads zero and ignores writes.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    // Next contents: one write per cycle, never into r0
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage; asynchronous reset clears every register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read ports with r0 forced to zero
    always_comb begin
        rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
        rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: splits the instruction, reads operands (with a
// write-through bypass from write-back) and registers the bundle for execute.
//
// Flow control: a bundle with VALID_OUT=1 is a real instruction. While
// STALL=1 execute is not consuming, so a held bundle stays put (only its
// operands may be refreshed by write-back) and INST_IN is not taken; fetch
// must keep presenting it. FLUSH beats STALL, which beats INST_VALID.
module id_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OPCD_W = DEF_OPCD_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [INST_W-1:0] INST_IN,
    input  logic [DATA_W-1:0] NPC_IN,
    input  logic              INST_VALID,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              WB_EN,
    input  logic [ADDR_W-1:0] WB_ADDR,
    input  logic [DATA_W-1:0] WB_DATA,
    output logic [DATA_W-1:0] NPC_OUT,
    output logic [DATA_W-1:0] REG_A,
    output logic [DATA_W-1:0] REG_B,
    output logic [DATA_W-1:0] IMM,
    output logic [OPCD_W-1:0] OPCD_OUT,
    output logic              OPT_BIT_OUT,
    output logic [ADDR_W-1:0] ADDR_REG_OUT,
    output logic              VALID_OUT,
    output logic [2:0]        ESTADO
);

    estado_e state_q, state_d;

    logic [DATA_W-1:0] npc_q, npc_d;
    logic [DATA_W-1:0] reg_a_q, reg_a_d;
    logic [DATA_W-1:0] reg_b_q, reg_b_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [OPCD_W-1:0] opcd_q, opcd_d;
    logic              opt_q, opt_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d;
    logic [ADDR_W-1:0] rs2_q, rs2_d;
    logic              valid_q, valid_d;

    logic [ADDR_W-1:0] inst_rs1, inst_rs2;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic [DATA_W-1:0] opnd_a, opnd_b;

    assign inst_rs1 = INST_IN[RS1_MSB:RS1_LSB];
    assign inst_rs2 = INST_IN[RS2_MSB:RS2_LSB];

    reg_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .CLK     (CLK),
        .RST     (RST),
        .we      (WB_EN),
        .waddr   (WB_ADDR),
        .wdata   (WB_DATA),
        .raddr_a (inst_rs1),
        .rdata_a (rf_a),
        .raddr_b (inst_rs2),
        .rdata_b (rf_b)
    );

    // Capture-cycle operands: a same-cycle write to a source wins over the array
    always_comb begin
        opnd_a = (WB_EN && (WB_ADDR == inst_rs1) && (inst_rs1 != '0)) ? WB_DATA : rf_a;
        opnd_b = (WB_EN && (WB_ADDR == inst_rs2) && (inst_rs2 != '0)) ? WB_DATA : rf_b;
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: FLUSH > STALL > INST_VALID; stall only holds a live bundle
    always_comb begin
        state_d = ST_IDLE;
        if (FLUSH) begin
            state_d = ST_FLUSH;
        end else if (STALL) begin
            case (state_q)
                ST_DECODE, ST_HOLD: state_d = ST_HOLD;
                ST_FLUSH:           state_d = ST_FLUSH;
                default:            state_d = ST_IDLE;
            endcase
        end else if (INST_VALID) begin
            state_d = ST_DECODE;
        end
    end

    // Next bundle: capture on DECODE, freeze with operand refresh on HOLD, else bubble
    always_comb begin
        npc_d   = '0;
        reg_a_d = '0;
        reg_b_d = '0;
        imm_d   = '0;
        opcd_d  = OPCD_NOP;
        opt_d   = 1'b0;
        rd_d    = '0;
        rs1_d   = '0;
        rs2_d   = '0;
        valid_d = 1'b0;
        case (state_d)
            ST_DECODE: begin
                npc_d   = NPC_IN;
                reg_a_d = opnd_a;
                reg_b_d = opnd_b;
                imm_d   = INST_IN[IMM_MSB:IMM_LSB];
                opcd_d  = INST_IN[OPCD_MSB:OPCD_LSB];
                opt_d   = INST_IN[OPT_POS];
                rd_d    = INST_IN[RD_MSB:RD_LSB];
                rs1_d   = inst_rs1;
                rs2_d   = inst_rs2;
                valid_d = 1'b1;
            end
            ST_HOLD: begin
                npc_d   = npc_q;
                reg_a_d = (WB_EN && (WB_ADDR == rs1_q) && (rs1_q != '0)) ? WB_DATA : reg_a_q;
                reg_b_d = (WB_EN && (WB_ADDR == rs2_q) && (rs2_q != '0)) ? WB_DATA : reg_b_q;
                imm_d   = imm_q;
                opcd_d  = opcd_q;
                opt_d   = opt_q;
                rd_d    = rd_q;
                rs1_d   = rs1_q;
                rs2_d   = rs2_q;
                valid_d = valid_q;
            end
            default: ;
        endcase
    end

    // Pipeline register towards execute
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            npc_q   <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            imm_q   <= '0;
            opcd_q  <= OPCD_NOP;
            opt_q   <= 1'b0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            npc_q   <= npc_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            imm_q   <= imm_d;
            opcd_q  <= opcd_d;
            opt_q   <= opt_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            valid_q <= valid_d;
        end
    end

    // Outputs straight from registers, state exposed for debug
    always_comb begin
        NPC_OUT      = npc_q;
        REG_A        = reg_a_q;
        REG_B        = reg_b_q;
        IMM          = imm_q;
        OPCD_OUT     = opcd_q;
        OPT_BIT_OUT  = opt_q;
        ADDR_REG_OUT = rd_q;
        VALID_OUT    = valid_q;
        ESTADO       = state_q;
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: scenario tasks push expected bundles to a queue as
// stimulus is applied and compare them against the outputs after each edge.
module tb_id_stage;
    import cpu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INST_IN;
    logic [15:0] NPC_IN;
    logic        INST_VALID, STALL, FLUSH, WB_EN;
    logic [4:0]  WB_ADDR;
    logic [15:0] WB_DATA;
    logic [15:0] NPC_OUT, REG_A, REG_B, IMM;
    logic [4:0]  OPCD_OUT, ADDR_REG_OUT;
    logic        OPT_BIT_OUT, VALID_OUT;
    logic [2:0]  ESTADO;

    always #5 CLK = ~CLK;

    id_stage dut (
        .CLK          (CLK),
        .RST          (RST),
        .INST_IN      (INST_IN),
        .NPC_IN       (NPC_IN),
        .INST_VALID   (INST_VALID),
        .STALL        (STALL),
        .FLUSH        (FLUSH),
        .WB_EN        (WB_EN),
        .WB_ADDR      (WB_ADDR),
        .WB_DATA      (WB_DATA),
        .NPC_OUT      (NPC_OUT),
        .REG_A        (REG_A),
        .REG_B        (REG_B),
        .IMM          (IMM),
        .OPCD_OUT     (OPCD_OUT),
        .OPT_BIT_OUT  (OPT_BIT_OUT),
        .ADDR_REG_OUT (ADDR_REG_OUT),
        .VALID_OUT    (VALID_OUT),
        .ESTADO       (ESTADO)
    );

    typedef struct packed {
        logic [15:0] npc;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [4:0]  opcd;
        logic        opt;
        logic [4:0]  addr;
        logic        valid;
        logic [2:0]  st;
    } out_t;

    out_t        exp_q[$];
    logic [15:0] ref_rf [32];
    int          total = 0;
    int          bad = 0;

    function automatic out_t sample();
        out_t o;
        o.npc = NPC_OUT; o.a = REG_A; o.b = REG_B; o.imm = IMM;
        o.opcd = OPCD_OUT; o.opt = OPT_BIT_OUT; o.addr = ADDR_REG_OUT;
        o.valid = VALID_OUT; o.st = ESTADO;
        return o;
    endfunction

    function automatic out_t bubble(logic [2:0] st);
        out_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic [31:0] mk_inst(logic [4:0] opcd, logic opt, logic [4:0] rd,
                                            logic [4:0] rs1, logic [4:0] rs2, logic [10:0] lo);
        return {opcd, opt, rd, rs1, rs2, lo};
    endfunction

    // Reference read: r0 is zero, a same-cycle write-back wins over the stored value
    function automatic logic [15:0] rd_model(logic [4:0] a);
        if (a == 5'd0) return 16'h0;
        if (WB_EN && (WB_ADDR == a)) return WB_DATA;
        return ref_rf[a];
    endfunction

    function automatic out_t decoded(logic [31:0] inst, logic [15:0] npc);
        out_t o;
        o.npc = npc;
        o.a = rd_model(inst[20:16]);
        o.b = rd_model(inst[15:11]);
        o.imm = inst[15:0];
        o.opcd = inst[31:27];
        o.opt = inst[26];
        o.addr = inst[25:21];
        o.valid = 1'b1;
        o.st = 3'd1;
        return o;
    endfunction

    task automatic drive_idle();
        INST_IN = '0; NPC_IN = '0; INST_VALID = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
        WB_EN = 1'b0; WB_ADDR = '0; WB_DATA = '0;
    endtask

    task automatic wb(logic en, logic [4:0] addr, logic [15:0] data);
        WB_EN = en; WB_ADDR = addr; WB_DATA = data;
    endtask

    // One clock edge; the reference array takes the write-back of that edge
    task automatic tick();
        @(posedge CLK);
        if (RST && WB_EN && (WB_ADDR != 5'd0)) ref_rf[WB_ADDR] = WB_DATA;
        #1;
    endtask

    task automatic test_reset();
        out_t obs, exp;
        RST = 1'b0;
        foreach (ref_rf[i]) ref_rf[i] = 16'h0;
        for (int i = 0; i < 3; i++) begin
            INST_IN = $urandom; NPC_IN = 16'($urandom);
            INST_VALID = 1'($urandom_range(0, 1)); STALL = 1'($urandom_range(0, 1));
            FLUSH = 1'($urandom_range(0, 1));
            wb(1'($urandom_range(0, 1)), 5'($urandom), 16'($urandom));
            exp_q.push_back(bubble(3'd0));
            tick();
            obs = sample(); exp = exp_q.pop_front(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL reset_held[%0d]: got %h want %h", i, obs, exp);
            end
        end
        drive_idle();
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            STALL = 1'($urandom_range(0, 1));
            exp_q.push_back(bubble(3'd0));
            tick();
            obs = sample(); exp = exp_q.pop_front(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL reset_release[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_decode();
        out_t obs, exp, want;
        drive_idle();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) wb(1'b1, 5'd3, 16'h00A5);
            else        wb(1'b1, 5'd4, 16'h1234);
            exp_q.push_back(bubble(3'd0));
            tick();
            obs = sample(); exp = exp_q.pop_front(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL decode_idle_wb[%0d]: got %h want %h", i, obs, exp);
            end
        end
        wb(1'b0, 5'd0, 16'h0);
        INST_IN = mk_inst(5'd2, 1'b0, 5'd7, 5'd3, 5'd4, 11'd0);
        NPC_IN = 16'h0010; INST_VALID = 1'b1;
        want = '0;
        want.npc = 16'h0010; want.a = 16'h00A5; want.b = 16'h1234; want.imm = 16'h2000;
        want.opcd = 5'd2; want.opt = 1'b0; want.addr = 5'd7; want.valid = 1'b1; want.st = 3'd1;
        exp_q.push_back(want);
        tick();
        obs = sample(); exp = exp_q.pop_front(); total++;
        if (obs !== exp) begin
            bad++; $display("FAIL decode_basic: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_bypass_r0();
        out_t obs, exp;
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            case (i)
                0: begin
                    INST_IN = mk_inst(5'd4, 1'b1, 5'd9, 5'd5, 5'd0, 11'h155);
                    NPC_IN = 16'h0014; INST_VALID = 1'b1;
                    wb(1'b1, 5'd5, 16'hBEEF);
                end
                1: wb(1'b1, 5'd0, 16'hFFFF);
                default: begin
                    INST_IN = mk_inst(5'd1, 1'b0, 5'd2, 5'd0, 5'd5, 11'h0);
                    NPC_IN = 16'h0018; INST_VALID = 1'b1;
                    wb(1'b1, 5'd0, 16'h1111);
                end
            endcase
            if (i == 1) exp_q.push_back(bubble(3'd0));
            else        exp_q.push_back(decoded(INST_IN, NPC_IN));
            tick();
            obs = sample(); exp = exp_q.pop_front(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL bypass_r0[%0d]: got %h want %h", i, obs, exp);
            end
        end
        total++;
        if (REG_A !== 16'h0 || REG_B !== 16'hBEEF) begin
            bad++; $display("FAIL r0_read: got a=%h b=%h want a=0000 b=beef", REG_A, REG_B);
        end
    endtask

    task automatic test_stall_refresh();
        out_t obs, exp, held;
        drive_idle();
        INST_IN = mk_inst(5'd3, 1'b0, 5'd10, 5'd3, 5'd4, 11'h0AB);
        NPC_IN = 16'h0020; INST_VALID = 1'b1;
        held = decoded(INST_IN, NPC_IN);
        exp_q.push_back(held);
        tick();
        obs = sample(); exp = exp_q.pop_front(); total++;
        if (obs !== exp) begin
            bad++; $display("FAIL stall_capture: got %h want %h", obs, exp);
        end
        for (int i = 1; i <= 3; i++) begin
            STALL = 1'b1; INST_VALID = 1'b1;
            INST_IN = mk_inst(5'd7, 1'b1, 5'd1, 5'd1, 5'd1, 11'h2A);
            NPC_IN = 16'h0030;
            if (i == 2) begin
                wb(1'b1, 5'd3, 16'h7777);
                held.a = 16'h7777;
            end else begin
                wb(1'b0, 5'd0, 16'h0);
            end
            held.st = 3'd2;
            exp_q.push_back(held);
            tick();
            obs = sample(); exp = exp_q.pop_front(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, exp);
            end
        end
        STALL = 1'b0; wb(1'b0, 5'd0, 16'h0);
        exp_q.push_back(decoded(INST_IN, NPC_IN));
        tick();
        obs = sample(); exp = exp_q.pop_front(); total++;
        if (obs !== exp) begin
            bad++; $display("FAIL stall_release: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_flush();
        out_t obs, exp;
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            case (i)
                0: begin
                    FLUSH = 1'b1; STALL = 1'b1; INST_VALID = 1'b1;
                    INST_IN = mk_inst(5'd9, 1'b1, 5'd3, 5'd3, 5'd3, 11'h7FF); NPC_IN = 16'h0040;
                    exp_q.push_back(bubble(3'd3));
                end
                1: begin
                    INST_VALID = 1'b1;
                    INST_IN = mk_inst(5'd5, 1'b0, 5'd11, 5'd4, 5'd3, 11'h011); NPC_IN = 16'h0044;
                    exp_q.push_back(decoded(INST_IN, NPC_IN));
                end
                2: exp_q.push_back(bubble(3'd0));
                3: begin
                    STALL = 1'b1; INST_VALID = 1'b1;
                    INST_IN = mk_inst(5'd6, 1'b0, 5'd1, 5'd3, 5'd4, 11'h0); NPC_IN = 16'h0048;
                    exp_q.push_back(bubble(3'd0));
                end
                4: begin
                    FLUSH = 1'b1;
                    wb(1'b1, 5'd6, 16'h5A5A);
                    exp_q.push_back(bubble(3'd3));
                end
                default: begin
                    INST_VALID = 1'b1;
                    INST_IN = mk_inst(5'd6, 1'b0, 5'd12, 5'd6, 5'd3, 11'h0); NPC_IN = 16'h004C;
                    exp_q.push_back(decoded(INST_IN, NPC_IN));
                end
            endcase
            tick();
            obs = sample(); exp = exp_q.pop_front(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL flush[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_t obs, exp;
        for (int i = 0; i < 8; i++) begin
            drive_idle();
            INST_VALID = 1'b1;
            INST_IN = $urandom; NPC_IN = 16'($urandom);
            wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom));
            if (i % 3 == 0) wb(1'b1, INST_IN[20:16], 16'($urandom));
            exp_q.push_back(decoded(INST_IN, NPC_IN));
            tick();
            obs = sample(); exp = exp_q.pop_front(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_async_reset_hold();
        out_t obs, exp, held;
        drive_idle();
        INST_VALID = 1'b1;
        INST_IN = mk_inst(5'd8, 1'b0, 5'd13, 5'd6, 5'd3, 11'h0); NPC_IN = 16'h0050;
        held = decoded(INST_IN, NPC_IN);
        tick();
        STALL = 1'b1;
        held.st = 3'd2;
        exp_q.push_back(held);
        tick();
        obs = sample(); exp = exp_q.pop_front(); total++;
        if (obs !== exp) begin
            bad++; $display("FAIL areset_hold: got %h want %h", obs, exp);
        end
        #3;
        RST = 1'b0;
        exp_q.push_back(bubble(3'd0));
        #1;
        obs = sample(); exp = exp_q.pop_front(); total++;
        if (obs !== exp) begin
            bad++; $display("FAIL areset_immediate: got %h want %h", obs, exp);
        end
        #1;
        RST = 1'b1;
        foreach (ref_rf[i]) ref_rf[i] = 16'h0;
        exp_q.push_back(bubble(3'd0));
        tick();
        obs = sample(); exp = exp_q.pop_front(); total++;
        if (obs !== exp) begin
            bad++; $display("FAIL areset_after_stall: got %h want %h", obs, exp);
        end
        STALL = 1'b0;
        exp_q.push_back(decoded(INST_IN, NPC_IN));
        tick();
        obs = sample(); exp = exp_q.pop_front(); total++;
        if (obs !== exp) begin
            bad++; $display("FAIL areset_regs_cleared: got %h want %h", obs, exp);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_decode();
        test_bypass_r0();
        test_stall_refresh();
        test_flush();
        test_back_to_back();
        test_async_reset_hold();
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

endmodule
